// File: rtl/btn_conditioner.sv
// btn_conditioner
// Brings the raw board pushbuttons into the clk domain, debounces each one,
// and produces a clean level, one-cycle press/release pulses and auto-repeat
// pulses for held buttons. Every button runs through an identical,
// independent channel.

module btn_conditioner #(
  parameter int N_BTN      = 5,         // bit order {down, right, left, up, cen}
  parameter int DB_CYCLES  = 1000000,   // stable samples needed to accept a new level
  parameter int DB_W       = 20,        // 2^DB_W > DB_CYCLES
  parameter int RPT_DELAY  = 40000000,  // press to first repeat
  parameter int RPT_PERIOD = 10000000,  // between later repeats
  parameter int RPT_W      = 26         // 2^RPT_W > max(RPT_DELAY, RPT_PERIOD)
) (
  input  logic             clk,
  input  logic             main_rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  // The repeat counter never needs to count past the longer of the two
  // intervals, so that value doubles as its saturation point.
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;

  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE       = DB_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(RPT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(RPT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_MAX_V    = RPT_W'(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_ONE      = RPT_W'(1);

  logic [N_BTN-1:0] s0_q, s0_d;
  logic [N_BTN-1:0] s1_q, s1_d;

  // Two-stage synchroniser input: s0 captures the pins, s1 follows s0.
  always_comb begin
    s0_d = btn_in;
    s1_d = s0_q;
  end

  // Synchroniser flops; everything downstream looks only at s1_q.
  always_ff @(posedge clk) begin
    if (!main_rst) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan

    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             first_q, first_d;
    logic             rpt_hit;

    // Debounce: count consecutive samples that disagree with the accepted
    // level, accept the new level when the run is long enough, and flag the
    // edge so the press/release pulse lines up with the level change.
    always_comb begin
      db_cnt_d  = db_cnt_q;
      stable_d  = stable_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s1_q[g] == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        stable_d  = s1_q[g];
        db_cnt_d  = '0;
        press_d   = s1_q[g];
        release_d = ~s1_q[g];
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end

    // Repeat pulse is decoded from registered state; gating on the level
    // means a release landing on a repeat boundary suppresses that repeat,
    // and gating on press keeps the two pulses mutually exclusive.
    always_comb begin
      rpt_hit = 1'b0;
      if (stable_q && !press_q) begin
        if (first_q) begin
          rpt_hit = (rpt_cnt_q == RPT_DELAY_V);
        end else begin
          rpt_hit = (rpt_cnt_q == RPT_PERIOD_V);
        end
      end
    end

    // Repeat timer: restarts on the press, reloads after every repeat,
    // clears while released, and saturates rather than wrapping.
    always_comb begin
      rpt_cnt_d = rpt_cnt_q;
      first_d   = first_q;
      if (!stable_q) begin
        rpt_cnt_d = '0;
        first_d   = 1'b0;
      end else if (press_q) begin
        rpt_cnt_d = RPT_ONE;
        first_d   = 1'b1;
      end else if (rpt_hit) begin
        rpt_cnt_d = RPT_ONE;
        first_d   = 1'b0;
      end else if (rpt_cnt_q != RPT_MAX_V) begin
        rpt_cnt_d = rpt_cnt_q + RPT_ONE;
      end
    end

    // Per-channel state; reset wins over every other update.
    always_ff @(posedge clk) begin
      if (!main_rst) begin
        db_cnt_q  <= '0;
        stable_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        rpt_cnt_q <= '0;
        first_q   <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        stable_q  <= stable_d;
        press_q   <= press_d;
        release_q <= release_d;
        rpt_cnt_q <= rpt_cnt_d;
        first_q   <= first_d;
      end
    end

    assign btn_level[g]   = stable_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_repeat[g]  = rpt_hit;

  end : g_chan

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
// Directed scenarios followed by randomized button activity, every cycle
// compared against a window/arithmetic reference model of the conditioner.

module tb_btn_conditioner;

  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         main_rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .DB_W(4),
    .RPT_DELAY(RD), .RPT_PERIOD(RP), .RPT_W(5)
  ) dut (
    .clk(clk), .main_rst(main_rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // reference model state
  logic [N-1:0] m_s0 = '0, m_s1 = '0;
  logic [N-1:0] m_lvl = '0, m_press = '0, m_rel = '0, m_rep = '0;
  logic [N-1:0] m_hist[$];
  int           press_cyc[N];

  // observed pulse bookkeeping for the directed scenarios
  int cnt_press[N], cnt_rel[N], cnt_rep[N], cnt_lvl[N];
  int obs_press_cyc[N], obs_rep_cyc[N];

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clearCounts();
    for (int b = 0; b < N; b++) begin
      cnt_press[b] = 0; cnt_rel[b] = 0; cnt_rep[b] = 0; cnt_lvl[b] = 0;
      obs_press_cyc[b] = -1; obs_rep_cyc[b] = -1;
    end
  endtask

  // Level flips once the last DB synchronised samples all disagree with it;
  // repeats fall at RD, RD+RP, RD+2RP ... cycles after the press.
  task automatic updateModel(input logic rst, input logic [N-1:0] din);
    logic [N-1:0] sample, nl;
    bit           all_diff;
    int           d;
    cyc++;
    if (!rst) begin
      m_s0 = '0; m_s1 = '0; m_hist.delete();
      m_lvl = '0; m_press = '0; m_rel = '0; m_rep = '0;
    end else begin
      sample = m_s1;
      m_s1   = m_s0;
      m_s0   = din;
      m_hist.push_back(sample);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      nl = m_lvl;
      for (int b = 0; b < N; b++) begin
        if (m_hist.size() == DB) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][b] == m_lvl[b]) all_diff = 1'b0;
          if (all_diff) nl[b] = ~m_lvl[b];
        end
      end
      m_press = nl & ~m_lvl;
      m_rel   = m_lvl & ~nl;
      m_lvl   = nl;
      for (int b = 0; b < N; b++) begin
        if (m_press[b]) press_cyc[b] = cyc;
        m_rep[b] = 1'b0;
        if (m_lvl[b] && !m_press[b]) begin
          d = cyc - press_cyc[b];
          if (d >= RD && ((d - RD) % RP) == 0) m_rep[b] = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("level",   32'(btn_level),   32'(m_lvl));
    checkValue("press",   32'(btn_press),   32'(m_press));
    checkValue("release", 32'(btn_release), 32'(m_rel));
    checkValue("repeat",  32'(btn_repeat),  32'(m_rep));
    for (int b = 0; b < N; b++) begin
      if (btn_press[b] === 1'b1) begin
        cnt_press[b]++;
        if (obs_press_cyc[b] < 0) obs_press_cyc[b] = cyc;
      end
      if (btn_repeat[b] === 1'b1) begin
        cnt_rep[b]++;
        if (obs_rep_cyc[b] < 0) obs_rep_cyc[b] = cyc;
      end
      if (btn_release[b] === 1'b1) cnt_rel[b]++;
      if (btn_level[b] === 1'b1) cnt_lvl[b]++;
    end
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample 1 after.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] din);
    @(negedge clk);
    main_rst = rst;
    btn_in   = din;
    @(posedge clk);
    updateModel(rst, din);
    #1;
    checkOutput();
  endtask

  task automatic holdFor(input int n, input logic [N-1:0] din);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, din);
  endtask

  initial begin
    int t0;
    int hold;
    logic [N-1:0] rv;

    main_rst = 1'b0;
    btn_in   = '0;
    for (int b = 0; b < N; b++) press_cyc[b] = 0;
    clearCounts();

    // reset state
    $display("[TB] reset");
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checkValue("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
    holdFor(4, '0);

    // clean press on cen
    $display("[TB] clean press");
    clearCounts();
    applyStimulus(1'b1, 5'b00001);
    t0 = cyc;
    holdFor(7, 5'b00001);
    holdFor(12, 5'b00000);
    checkValue("clean_press_count", 32'(cnt_press[0]), 32'd1);
    checkValue("clean_press_edge", 32'(obs_press_cyc[0] - t0), 32'd5);
    checkValue("clean_release_count", 32'(cnt_rel[0]), 32'd1);
    checkValue("clean_others_quiet", 32'(cnt_press[1] + cnt_press[2] + cnt_press[3] + cnt_press[4]), 32'd0);

    // bounce on left
    $display("[TB] bounce rejection");
    clearCounts();
    holdFor(2, 5'b00100);
    holdFor(2, 5'b00000);
    holdFor(2, 5'b00100);
    holdFor(2, 5'b00000);
    checkValue("bounce_level_quiet", 32'(cnt_lvl[2]), 32'd0);
    applyStimulus(1'b1, 5'b00100);
    t0 = cyc;
    holdFor(11, 5'b00100);
    checkValue("bounce_press_count", 32'(cnt_press[2]), 32'd1);
    checkValue("bounce_press_edge", 32'(obs_press_cyc[2] - t0), 32'd5);
    holdFor(10, 5'b00000);
    checkValue("bounce_release_count", 32'(cnt_rel[2]), 32'd1);

    // auto-repeat on right
    $display("[TB] auto-repeat");
    clearCounts();
    for (int i = 0; i < 12 && cnt_press[3] == 0; i++) applyStimulus(1'b1, 5'b01000);
    checkValue("repeat_press_seen", 32'(cnt_press[3]), 32'd1);
    t0 = obs_press_cyc[3];
    holdFor(30 - (cyc - t0), 5'b01000);
    checkValue("repeat_count_30", 32'(cnt_rep[3]), 32'd7);
    checkValue("repeat_first_offset", 32'(obs_rep_cyc[3] - t0), 32'd10);
    clearCounts();
    holdFor(15, 5'b00000);
    checkValue("repeat_release_count", 32'(cnt_rel[3]), 32'd1);

    // simultaneous press
    $display("[TB] simultaneous press");
    clearCounts();
    for (int i = 0; i < 12 && btn_press === 5'b00000; i++) applyStimulus(1'b1, 5'b10011);
    checkValue("simul_press", 32'(btn_press), 32'h13);
    holdFor(3, 5'b10011);
    holdFor(12, 5'b00000);
    checkValue("simul_release_count", 32'(cnt_rel[0] + cnt_rel[1] + cnt_rel[4]), 32'd3);

    // reset while up is held
    $display("[TB] reset mid-hold");
    holdFor(8, 5'b00010);
    checkValue("midhold_level_before", 32'(btn_level[1]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'b00010);
      checkValue("midhold_reset_zero", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
    end
    clearCounts();
    applyStimulus(1'b1, 5'b00010);
    t0 = cyc;
    holdFor(9, 5'b00010);
    checkValue("midhold_press_edge", 32'(obs_press_cyc[1] - t0), 32'd5);
    holdFor(12, 5'b00000);

    // short glitch on down
    $display("[TB] short glitch");
    clearCounts();
    holdFor(3, 5'b10000);
    holdFor(12, 5'b00000);
    checkValue("glitch_level", 32'(cnt_lvl[4]), 32'd0);
    checkValue("glitch_press", 32'(cnt_press[4]), 32'd0);
    checkValue("glitch_release", 32'(cnt_rel[4]), 32'd0);

    // randomized activity, with the occasional reset
    $display("[TB] random");
    for (int i = 0; i < 120; i++) begin
      rv   = N'($urandom);
      hold = int'($urandom_range(1, 9));
      if ($urandom_range(0, 39) == 0) begin
        for (int j = 0; j < hold; j++) applyStimulus(1'b0, rv);
      end else begin
        holdFor(hold, rv);
      end
    end
    holdFor(40, 5'b11111);
    holdFor(12, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
